// File: rtl/core_run_pkg.sv
// Shared types and constants for the core run-control block.
// State encoding, EBREAK opcode and the default halt mailbox address.
package core_run_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        STEP = 2'd3
    } run_state_t;

    localparam logic [31:0] EBREAK_INSN   = 32'h0010_0073;
    localparam logic [31:0] DEF_HALT_ADDR = 32'h0000_0FFC;

endpackage

// File: rtl/reset_sync.sv
// Two-flop active-low reset synchronizer.
// Assertion is asynchronous, release is aligned to clk.
module reset_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic meta;

    // Shift a constant one through two flops after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta       <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            meta       <= 1'b1;
            rst_sync_n <= meta;
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// Run control: stretched core reset, PC gating, halt/resume/step.
// Define RUN_CTRL_COUNTERS_EN to build the cycle/instret counters.
module core_run_ctrl
    import core_run_pkg::*;
#(
    parameter int unsigned STRETCH_CYCLES = 4,
    parameter logic [31:0] HALT_ADDR      = DEF_HALT_ADDR,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      Instr,
    input  logic             MemWrite,
    input  logic [31:0]      ALUResult,
    input  logic [31:0]      WriteData,
    input  logic             Resume,
    output logic             Core_RST_n,
    output logic             PC_En,
    output logic             Halted,
    output logic [31:0]      Halt_Code,
    output logic [CNT_W-1:0] Cycle_Cnt,
    output logic [CNT_W-1:0] Instret_Cnt
);

    localparam logic [7:0] STR_LAST = 8'(STRETCH_CYCLES - 1);

    run_state_t state_q;
    run_state_t state_d;
    logic       sync_n;
    logic [7:0] stretch_q;
    logic       is_ebreak;
    logic       is_mbox;
    logic       halt_hit;

    reset_sync u_sync (
        .clk        (CLK),
        .rst_n      (RST),
        .rst_sync_n (sync_n)
    );

    assign is_ebreak = (Instr == EBREAK_INSN);
    assign is_mbox   = MemWrite && (ALUResult == HALT_ADDR);
    assign halt_hit  = is_ebreak || is_mbox;

    // Count cycles since synchronized release while held in HOLD.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stretch_q <= 8'd0;
        end else if (state_q == HOLD && sync_n) begin
            stretch_q <= stretch_q + 8'd1;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and PC gating; STEP ignores halt_hit.
    always_comb begin
        state_d = state_q;
        PC_En   = 1'b0;
        unique case (state_q)
            HOLD: begin
                if (sync_n && stretch_q == STR_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                PC_En = !halt_hit;
                if (halt_hit) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (Resume) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                PC_En   = 1'b1;
                state_d = RUN;
            end
            default: state_d = HOLD;
        endcase
    end

    assign Core_RST_n = (state_q != HOLD);
    assign Halted     = (state_q == HALT);

    // Capture the halt reason; EBREAK takes priority over the mailbox.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Halt_Code <= 32'd0;
        end else if (state_q == RUN && halt_hit) begin
            Halt_Code <= is_ebreak ? 32'd0 : WriteData;
        end
    end

`ifdef RUN_CTRL_COUNTERS_EN
    logic cyc_inc;
    logic ret_inc;

    // A halting mailbox store still retires; a halting EBREAK does not.
    assign cyc_inc = (state_q == RUN) || (state_q == STEP);
    assign ret_inc = PC_En || (state_q == RUN && is_mbox && !is_ebreak);

    // Saturating cycle counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Cycle_Cnt <= '0;
        end else if (cyc_inc && Cycle_Cnt != '1) begin
            Cycle_Cnt <= Cycle_Cnt + CNT_W'(1);
        end
    end

    // Saturating retired-instruction counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Instret_Cnt <= '0;
        end else if (ret_inc && Instret_Cnt != '1) begin
            Instret_Cnt <= Instret_Cnt + CNT_W'(1);
        end
    end
`else
    assign Cycle_Cnt   = '0;
    assign Instret_Cnt = '0;
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// Randomized self-checking bench for core_run_ctrl.
// A behavioural model is compared against the DUT every cycle.
module tb_core_run_ctrl;

    localparam int          S     = 4;
    localparam logic [31:0] HA    = 32'h0000_0FFC;
    localparam logic [31:0] EBRK  = 32'h0010_0073;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef RUN_CTRL_COUNTERS_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    localparam int M_HOLD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam int M_STEP = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] Instr = NOP;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        Resume = 1'b0;

    logic        rstn, pcen, halted;
    logic [31:0] code;
    logic [31:0] cyc32, ins32;
    logic        rstn4, pcen4, halted4;
    logic [31:0] code4;
    logic [3:0]  cyc4, ins4;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_on = 1'b1;

    core_run_ctrl #(.STRETCH_CYCLES(S), .HALT_ADDR(HA), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .Instr(Instr), .MemWrite(MemWrite),
        .ALUResult(ALUResult), .WriteData(WriteData), .Resume(Resume),
        .Core_RST_n(rstn), .PC_En(pcen), .Halted(halted),
        .Halt_Code(code), .Cycle_Cnt(cyc32), .Instret_Cnt(ins32)
    );

    core_run_ctrl #(.STRETCH_CYCLES(S), .HALT_ADDR(HA), .CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .Instr(Instr), .MemWrite(MemWrite),
        .ALUResult(ALUResult), .WriteData(WriteData), .Resume(Resume),
        .Core_RST_n(rstn4), .PC_En(pcen4), .Halted(halted4),
        .Halt_Code(code4), .Cycle_Cnt(cyc4), .Instret_Cnt(ins4)
    );

    always #5 CLK = ~CLK;

    // Model: mode, edges since release, halt code, raw event counts.
    int          m_mode  = M_HOLD;
    int          m_edges = 0;
    logic [31:0] m_code  = 32'd0;
    longint      m_cyc   = 0;
    longint      m_ins   = 0;

    always @(negedge RST) begin
        m_mode  <= M_HOLD;
        m_edges <= 0;
        m_code  <= 32'd0;
        m_cyc   <= 0;
        m_ins   <= 0;
    end

    always @(posedge CLK) begin
        if (RST) begin
            case (m_mode)
                M_HOLD: begin
                    m_edges <= m_edges + 1;
                    if (m_edges + 1 == 2 + S) m_mode <= M_RUN;
                end
                M_RUN: begin
                    m_cyc <= m_cyc + 1;
                    if (Instr == EBRK) begin
                        m_code <= 32'd0;
                        m_mode <= M_HALT;
                    end else if (MemWrite && ALUResult == HA) begin
                        m_code <= WriteData;
                        m_ins  <= m_ins + 1;
                        m_mode <= M_HALT;
                    end else begin
                        m_ins <= m_ins + 1;
                    end
                end
                M_HALT: if (Resume) m_mode <= M_STEP;
                default: begin
                    m_cyc  <= m_cyc + 1;
                    m_ins  <= m_ins + 1;
                    m_mode <= M_RUN;
                end
            endcase
        end
    end

    function automatic logic [63:0] sat(longint v, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        if (!CEN) return 64'd0;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        if (chk_on) begin
            logic hit;
            hit = (Instr == EBRK) || (MemWrite && ALUResult == HA);
            check("core_rst_n", 64'(rstn), 64'(m_mode != M_HOLD));
            check("pc_en", 64'(pcen),
                  64'((m_mode == M_RUN && !hit) || m_mode == M_STEP));
            check("halted", 64'(halted), 64'(m_mode == M_HALT));
            check("halt_code", 64'(code), 64'(m_code));
            check("cycle_cnt", 64'(cyc32), sat(m_cyc, 32));
            check("instret_cnt", 64'(ins32), sat(m_ins, 32));
            check("cycle_cnt_w4", 64'(cyc4), sat(m_cyc, 4));
            check("instret_cnt_w4", 64'(ins4), sat(m_ins, 4));
        end
    end

    task automatic cyc(input logic [31:0] ins, input logic mw,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic rs);
        @(posedge CLK);
        #2;
        Instr     = ins;
        MemWrite  = mw;
        ALUResult = a;
        WriteData = wd;
        Resume    = rs;
        @(negedge CLK);
        #1;
    endtask

    task automatic nop_cyc();
        cyc(NOP, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // Release sequence: core reset rises exactly on edge 2+S.
    task automatic release_seq(string tag);
        for (int k = 1; k <= 2 + S; k++) begin
            nop_cyc();
            if (k == 1 + S) begin
                check({tag, "_rstn_low"}, 64'(rstn), 64'd0);
                check({tag, "_cyc_zero"}, 64'(cyc32), 64'd0);
            end
        end
        check({tag, "_rstn_high"}, 64'(rstn), 64'd1);
        check({tag, "_pcen_high"}, 64'(pcen), 64'd1);
    endtask

    task automatic rst_pulse(string tag);
        @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        check({tag, "_rstn_async"}, 64'(rstn), 64'd0);
        check({tag, "_pcen_async"}, 64'(pcen), 64'd0);
        check({tag, "_cnt_clear"}, 64'(ins32), 64'd0);
        check({tag, "_cyc_clear"}, 64'(cyc32), 64'd0);
        #2 RST = 1'b1;
        release_seq(tag);
    endtask

    initial begin
        #32 RST = 1'b1;
        release_seq("por");

        for (int i = 0; i < 9; i++) nop_cyc();
        cyc(EBRK, 1'b0, 32'd0, 32'd0, 1'b0);
        check("ebrk_pcen", 64'(pcen), 64'd0);
        cyc(EBRK, 1'b0, 32'd0, 32'd0, 1'b0);
        check("ebrk_halted", 64'(halted), 64'd1);
        check("ebrk_code", 64'(code), 64'd0);
        check("ebrk_instret", 64'(ins32), CEN ? 64'd10 : 64'd0);

        cyc(EBRK, 1'b0, 32'd0, 32'd0, 1'b1);
        check("resume_wait", 64'(halted), 64'd1);
        cyc(EBRK, 1'b0, 32'd0, 32'd0, 1'b0);
        check("step_halted", 64'(halted), 64'd0);
        check("step_pcen", 64'(pcen), 64'd1);
        nop_cyc();
        check("post_step_run", 64'(pcen), 64'd1);

        cyc(NOP, 1'b1, HA, 32'hDEAD_BEEF, 1'b0);
        check("mbox_pcen", 64'(pcen), 64'd0);
        nop_cyc();
        check("mbox_halted", 64'(halted), 64'd1);
        check("mbox_code", 64'(code), 64'hDEAD_BEEF);
        check("mbox_instret", 64'(ins32), CEN ? 64'd13 : 64'd0);
        cyc(NOP, 1'b0, 32'd0, 32'd0, 1'b1);
        nop_cyc();
        check("mbox_step", 64'(pcen), 64'd1);

        cyc(EBRK, 1'b1, HA, 32'h1234_5678, 1'b0);
        nop_cyc();
        check("both_code", 64'(code), 64'd0);
        cyc(NOP, 1'b0, 32'd0, 32'd0, 1'b1);
        nop_cyc();

        rst_pulse("midrun");
        for (int i = 0; i < 20; i++) nop_cyc();
        check("w4_cyc_sat", 64'(cyc4), CEN ? 64'hF : 64'd0);
        check("w4_ins_sat", 64'(ins4), CEN ? 64'hF : 64'd0);

        cyc(EBRK, 1'b0, 32'd0, 32'd0, 1'b0);
        nop_cyc();
        rst_pulse("midhalt");

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ins, a;
            if ($urandom_range(0, 399) == 0) begin
                rst_pulse("rand");
            end else begin
                ins = ($urandom_range(0, 7) == 0) ? EBRK : $urandom;
                a   = ($urandom_range(0, 5) == 0) ? HA : $urandom;
                cyc(ins, 1'($urandom_range(0, 1)), a, $urandom,
                    ($urandom_range(0, 3) == 0));
            end
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
